// File: rtl/bsram_arb_pkg.sv
// Shared types and sizing for the cartridge BSRAM save-port arbiter.
package bsram_arb_pkg;

  localparam int BSRAM_AW     = 20;
  localparam int RAM_LAT_MAX  = 7;
  localparam int IDLE_GAP_MAX = 15;
  localparam int LAT_W        = $clog2(RAM_LAT_MAX + 1);
  localparam int GAP_W        = $clog2(IDLE_GAP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    ACCESS,
    DONE
  } arb_state_e;

  typedef struct packed {
    logic [BSRAM_AW-1:0] addr;
    logic [7:0]          data;
    logic                wr;
  } host_req_t;

endpackage

// File: rtl/bsram_dirty_tracker.sv
// Sticky set/clear flag; a set in the same cycle as a clear wins.
module bsram_dirty_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_flag
);

  logic r_flag;

  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_flag <= 1'b0;
    else if (i_set) r_flag <= 1'b1;
    else if (i_clr) r_flag <= 1'b0;
  end

  assign o_flag = r_flag;

endmodule

// File: rtl/bsram_save_arbiter.sv
// Shares the cartridge BSRAM between the active mapper (absolute priority)
// and the host save streamer, which only uses idle gaps in mapper traffic.
module bsram_save_arbiter
  import bsram_arb_pkg::*;
#(
  parameter int unsigned RAM_LAT  = 2,
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic                MCLK,
  input  logic                RESET_N,
  input  logic [BSRAM_AW-1:0] MAP_ADDR,
  input  logic [7:0]          MAP_D,
  output logic [7:0]          MAP_Q,
  input  logic                MAP_CE_N,
  input  logic                MAP_OE_N,
  input  logic                MAP_WE_N,
  input  logic [BSRAM_AW-1:0] HOST_ADDR,
  input  logic [7:0]          HOST_D,
  input  logic                HOST_RD,
  input  logic                HOST_WR,
  output logic [7:0]          HOST_Q,
  output logic                HOST_ACK,
  output logic [BSRAM_AW-1:0] RAM_ADDR,
  output logic [7:0]          RAM_D,
  input  logic [7:0]          RAM_Q,
  output logic                RAM_CE_N,
  output logic                RAM_OE_N,
  output logic                RAM_WE_N,
  output logic                DIRTY,
  input  logic                DIRTY_CLR
);

  arb_state_e       r_state, w_next;
  host_req_t        r_req;
  logic [GAP_W-1:0] r_gap;
  logic [LAT_W-1:0] r_lat;
  logic [7:0]       r_host_q;

  logic w_map_sel, w_host_req, w_gap_ok, w_last_beat;

  assign w_map_sel   = !MAP_CE_N;
  assign w_host_req  = HOST_RD | HOST_WR;
  assign w_gap_ok    = (r_gap == GAP_W'(IDLE_GAP)) && MAP_CE_N;
  assign w_last_beat = (r_state == ACCESS) && !w_map_sel && (r_lat == LAT_W'(1));

  // Counts consecutive mapper-idle cycles, saturating at the required gap.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N)                       r_gap <= '0;
    else if (w_map_sel)                 r_gap <= '0;
    else if (r_gap < GAP_W'(IDLE_GAP))  r_gap <= r_gap + GAP_W'(1);
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_host_req) w_next = GAP;
      GAP:     if (w_gap_ok)   w_next = ACCESS;
      ACCESS: begin
        if (w_map_sel)                 w_next = GAP;
        else if (r_lat == LAT_W'(1))   w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_lat    <= '0;
      r_host_q <= 8'h00;
    end else begin
      r_state <= w_next;
      // Simultaneous read and write requests are taken as a write.
      if (r_state == IDLE && w_host_req)
        r_req <= '{addr: HOST_ADDR, data: HOST_D, wr: HOST_WR};
      if (r_state == GAP && w_gap_ok)
        r_lat <= LAT_W'(RAM_LAT);
      else if (r_state == ACCESS && !w_map_sel)
        r_lat <= r_lat - LAT_W'(1);
      if (w_last_beat && !r_req.wr)
        r_host_q <= RAM_Q;
    end
  end

  // Mapper wins the bus combinationally in every state; an ACCESS it
  // interrupts is simply retried from GAP.
  always_comb begin
    RAM_ADDR = '0;
    RAM_D    = 8'h00;
    RAM_CE_N = 1'b1;
    RAM_OE_N = 1'b1;
    RAM_WE_N = 1'b1;
    if (!RESET_N) begin
      RAM_CE_N = 1'b1;
    end else if (w_map_sel) begin
      RAM_ADDR = MAP_ADDR;
      RAM_D    = MAP_D;
      RAM_CE_N = MAP_CE_N;
      RAM_OE_N = MAP_OE_N;
      RAM_WE_N = MAP_WE_N;
    end else if (r_state == ACCESS) begin
      RAM_ADDR = r_req.addr;
      RAM_D    = r_req.data;
      RAM_CE_N = 1'b0;
      RAM_OE_N = r_req.wr;
      RAM_WE_N = !r_req.wr;
    end
  end

  assign MAP_Q    = RAM_Q;
  assign HOST_Q   = r_host_q;
  assign HOST_ACK = (r_state == DONE);

  bsram_dirty_tracker u_dirty (
    .clk    (MCLK),
    .rst_n  (RESET_N),
    .i_set  (!MAP_CE_N && !MAP_WE_N),
    .i_clr  (DIRTY_CLR),
    .o_flag (DIRTY)
  );

endmodule

// File: tb/tb_bsram_save_arbiter.sv
// Directed bench for bsram_save_arbiter (RAM_LAT = 2, IDLE_GAP = 2) with a
// behavioural BSRAM model on the RAM port.
module tb_bsram_save_arbiter;

  logic        MCLK = 1'b0;
  logic        RESET_N;
  logic [19:0] MAP_ADDR;
  logic [7:0]  MAP_D;
  logic [7:0]  MAP_Q;
  logic        MAP_CE_N, MAP_OE_N, MAP_WE_N;
  logic [19:0] HOST_ADDR;
  logic [7:0]  HOST_D;
  logic        HOST_RD, HOST_WR;
  logic [7:0]  HOST_Q;
  logic        HOST_ACK;
  logic [19:0] RAM_ADDR;
  logic [7:0]  RAM_D;
  logic [7:0]  RAM_Q;
  logic        RAM_CE_N, RAM_OE_N, RAM_WE_N;
  logic        DIRTY;
  logic        DIRTY_CLR;

  int n_cmp = 0;
  int n_err = 0;

  always #5 MCLK = ~MCLK;

  bsram_save_arbiter #(.RAM_LAT(2), .IDLE_GAP(2)) dut (
    .MCLK      (MCLK),
    .RESET_N   (RESET_N),
    .MAP_ADDR  (MAP_ADDR),
    .MAP_D     (MAP_D),
    .MAP_Q     (MAP_Q),
    .MAP_CE_N  (MAP_CE_N),
    .MAP_OE_N  (MAP_OE_N),
    .MAP_WE_N  (MAP_WE_N),
    .HOST_ADDR (HOST_ADDR),
    .HOST_D    (HOST_D),
    .HOST_RD   (HOST_RD),
    .HOST_WR   (HOST_WR),
    .HOST_Q    (HOST_Q),
    .HOST_ACK  (HOST_ACK),
    .RAM_ADDR  (RAM_ADDR),
    .RAM_D     (RAM_D),
    .RAM_Q     (RAM_Q),
    .RAM_CE_N  (RAM_CE_N),
    .RAM_OE_N  (RAM_OE_N),
    .RAM_WE_N  (RAM_WE_N),
    .DIRTY     (DIRTY),
    .DIRTY_CLR (DIRTY_CLR)
  );

  // BSRAM model: combinational read while selected, write on the clock edge.
  logic [7:0] mem [0:(1<<20)-1];
  assign RAM_Q = (!RAM_CE_N && !RAM_OE_N) ? mem[RAM_ADDR] : 8'h00;
  always @(posedge MCLK)
    if (!RAM_CE_N && !RAM_WE_N) mem[RAM_ADDR] <= RAM_D;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic map_idle();
    MAP_CE_N = 1'b1;
    MAP_OE_N = 1'b1;
    MAP_WE_N = 1'b1;
  endtask

  task automatic map_write(input logic [19:0] addr, input logic [7:0] data);
    MAP_ADDR = addr;
    MAP_D    = data;
    MAP_CE_N = 1'b0;
    MAP_WE_N = 1'b0;
    MAP_OE_N = 1'b1;
    tick();
    map_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ack_idx, ack_cnt, strobe_cnt, bad_cnt;

    // Reset with the mapper actively writing: strobes must still be high.
    RESET_N   = 1'b0;
    MAP_ADDR  = 20'h55555;
    MAP_D     = 8'hFF;
    MAP_CE_N  = 1'b0;
    MAP_OE_N  = 1'b1;
    MAP_WE_N  = 1'b0;
    HOST_ADDR = '0;
    HOST_D    = '0;
    HOST_RD   = 1'b0;
    HOST_WR   = 1'b0;
    DIRTY_CLR = 1'b0;
    tick();
    tick();
    check("rst_ram_ce_n", RAM_CE_N, 1);
    check("rst_ram_we_n", RAM_WE_N, 1);
    check("rst_ram_addr", RAM_ADDR, 0);
    check("rst_ram_d",    RAM_D,    0);
    check("rst_host_ack", HOST_ACK, 0);
    check("rst_host_q",   HOST_Q,   0);
    check("rst_dirty",    DIRTY,    0);
    map_idle();
    RESET_N = 1'b1;
    repeat (3) tick();

    // Mapper write 0x00123 <= 0xA5 passes straight through.
    MAP_ADDR = 20'h00123;
    MAP_D    = 8'hA5;
    MAP_CE_N = 1'b0;
    MAP_WE_N = 1'b0;
    #1;
    check("map_pass_addr", RAM_ADDR, 20'h00123);
    check("map_pass_d",    RAM_D,    8'hA5);
    check("map_pass_we_n", RAM_WE_N, 0);
    check("map_pass_ce_n", RAM_CE_N, 0);
    tick();
    map_idle();

    // Host read straight after mapper traffic: worst-case latency, ACK in the
    // sixth cycle counting the request cycle as the first (index 5).
    HOST_ADDR = 20'h00123;
    HOST_RD   = 1'b1;
    ack_idx = -1; ack_cnt = 0; strobe_cnt = 0; bad_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (!RAM_CE_N && !RAM_OE_N) begin
        strobe_cnt++;
        if (RAM_ADDR !== 20'h00123) bad_cnt++;
      end
      if (HOST_ACK === 1'b1) begin
        ack_cnt++;
        if (ack_idx < 0) ack_idx = k;
        HOST_RD = 1'b0;
      end
      tick();
    end
    check("rd_ack_idx",   ack_idx,    5);
    check("rd_ack_cnt",   ack_cnt,    1);
    check("rd_oe_cycles", strobe_cnt, 2);
    check("rd_addr_bad",  bad_cnt,    0);
    check("rd_host_q",    HOST_Q,     8'hA5);

    // Dirty flag: preload write set it; clear, set, set-vs-clear, clear.
    check("dirty_after_preload", DIRTY, 1);
    DIRTY_CLR = 1'b1; tick(); DIRTY_CLR = 1'b0;
    check("dirty_clr_1", DIRTY, 0);
    map_write(20'h00000, 8'h11);
    check("dirty_set", DIRTY, 1);
    DIRTY_CLR = 1'b1;
    map_write(20'h00000, 8'h11);
    DIRTY_CLR = 1'b0;
    check("dirty_set_wins", DIRTY, 1);
    DIRTY_CLR = 1'b1; tick(); DIRTY_CLR = 1'b0;
    check("dirty_clr_2", DIRTY, 0);

    // Host write 0x00010 <= 0x3C.
    HOST_ADDR = 20'h00010;
    HOST_D    = 8'h3C;
    HOST_WR   = 1'b1;
    ack_cnt = 0; strobe_cnt = 0; bad_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (!RAM_CE_N && !RAM_WE_N) begin
        strobe_cnt++;
        if (RAM_D !== 8'h3C || RAM_ADDR !== 20'h00010) bad_cnt++;
      end
      if (HOST_ACK === 1'b1) begin
        ack_cnt++;
        HOST_WR = 1'b0;
      end
      tick();
    end
    check("wr_we_cycles", strobe_cnt, 2);
    check("wr_data_bad",  bad_cnt,    0);
    check("wr_ack_cnt",   ack_cnt,    1);
    check("wr_dirty",     DIRTY,      0);
    check("wr_host_q_held", HOST_Q,   8'hA5);
    MAP_ADDR = 20'h00010;
    MAP_CE_N = 1'b0;
    MAP_OE_N = 1'b0;
    #1;
    check("wr_map_readback", MAP_Q, 8'h3C);
    tick();
    map_idle();

    // Preemption: host read of 0x00200, mapper takes the bus in the first
    // ACCESS cycle (index 3), then the retry completes.
    map_write(20'h00200, 8'h5A);
    HOST_ADDR = 20'h00200;
    HOST_RD   = 1'b1;
    ack_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (HOST_ACK === 1'b1) ack_cnt++;
      tick();
    end
    MAP_ADDR = 20'h00010;
    MAP_CE_N = 1'b0;
    MAP_OE_N = 1'b0;
    #1;
    check("pre_ram_addr", RAM_ADDR, 20'h00010);
    check("pre_ram_oe_n", RAM_OE_N, 0);
    check("pre_map_q",    MAP_Q,    8'h3C);
    check("pre_no_ack",   HOST_ACK, 0);
    tick();
    map_idle();
    ack_idx = -1; strobe_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (!RAM_CE_N && !RAM_OE_N) strobe_cnt++;
      if (HOST_ACK === 1'b1) begin
        ack_cnt++;
        if (ack_idx < 0) ack_idx = k;
        HOST_RD = 1'b0;
      end
      tick();
    end
    check("pre_retry_ack_idx", ack_idx,    5);
    check("pre_ack_cnt",       ack_cnt,    1);
    check("pre_retry_oe",      strobe_cnt, 2);
    check("pre_host_q",        HOST_Q,     8'h5A);

    // Continuous mapper reads with single-cycle gaps starve the host.
    HOST_ADDR = 20'h00123;
    HOST_RD   = 1'b1;
    ack_cnt = 0; strobe_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      MAP_ADDR = 20'h00000;
      MAP_CE_N = (k % 2 == 1);
      MAP_OE_N = (k % 2 == 1);
      #1;
      if (MAP_CE_N && !RAM_CE_N) strobe_cnt++;
      if (HOST_ACK === 1'b1) ack_cnt++;
      tick();
    end
    map_idle();
    check("busy_host_strobes", strobe_cnt, 0);
    check("busy_ack_cnt",      ack_cnt,    0);
    ack_idx = -1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (HOST_ACK === 1'b1) begin
        ack_cnt++;
        if (ack_idx < 0) ack_idx = k;
        HOST_RD = 1'b0;
      end
      tick();
    end
    check("busy_after_ack_idx", ack_idx, 4);
    check("busy_after_ack_cnt", ack_cnt, 1);
    check("busy_host_q",        HOST_Q,  8'hA5);

    // Async reset in the middle of a host write.
    map_write(20'h00000, 8'h22);
    repeat (4) tick();
    check("rstw_dirty_pre", DIRTY, 1);
    HOST_ADDR = 20'h00020;
    HOST_D    = 8'h77;
    HOST_WR   = 1'b1;
    tick();
    tick();
    #1;
    check("rstw_we_active", RAM_WE_N, 0);
    RESET_N = 1'b0;
    #1;
    check("rstw_we_n",   RAM_WE_N, 1);
    check("rstw_ce_n",   RAM_CE_N, 1);
    check("rstw_addr",   RAM_ADDR, 0);
    HOST_WR = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    check("rstw_host_ack", HOST_ACK, 0);
    check("rstw_host_q",   HOST_Q,   0);
    check("rstw_dirty",    DIRTY,    0);
    ack_cnt = 0; strobe_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (HOST_ACK === 1'b1) ack_cnt++;
      if (!RAM_CE_N) strobe_cnt++;
      tick();
    end
    check("rstw_idle_ack",     ack_cnt,    0);
    check("rstw_idle_strobes", strobe_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
